// File: rtl/oam_dma_ctrl.sv
// Bus arbiter between the CPU memory port and the shared system bus.
// It also runs the OAM DMA copy that the CPU triggers by writing the DMA register.
module oam_dma_ctrl #(
   parameter int          DMA_LEN      = 160,
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] OAM_BASE     = 16'hFE00
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [15:0] iCpuAddr,
   input  logic [7:0]  iCpuData,
   input  logic        iCpuWe,
   output logic [7:0]  oCpuData,
   output logic [15:0] oMemAddr,
   output logic [7:0]  oMemData,
   output logic        oMemWe,
   input  logic [7:0]  iMemData,
   output logic        oDmaBusy,
   output logic        oDmaDone
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      READ,
      WRITE
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   state_t     rState;
   state_t     state_next;
   logic [7:0] rSrc;
   logic [7:0] rIdx;
   logic [7:0] rByte;

   logic reg_hit;
   logic start_req;
   logic last_byte;

   assign reg_hit   = (iCpuAddr == DMA_REG_ADDR);
   assign start_req = (rState == IDLE) && reg_hit && iCpuWe;
   assign last_byte = (rIdx == LAST_IDX);

   // Only an idle controller accepts the trigger, so writes during a copy never restart it.
   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         rState   <= IDLE;
         rSrc     <= 8'h00;
         rIdx     <= 8'h00;
         rByte    <= 8'h00;
         oDmaDone <= 1'b0;
      end else begin
         rState   <= state_next;
         oDmaDone <= (rState == WRITE) && last_byte;
         if (start_req) begin
            rSrc <= iCpuData;
            rIdx <= 8'h00;
         end
         if (rState == READ) begin
            rByte <= iMemData;
         end
         if ((rState == WRITE) && !last_byte) begin
            rIdx <= rIdx + 8'h01;
         end
      end
   end

   // While busy the bus belongs to the copy; the CPU sees 0xFF except for the DMA register.
   always_comb begin
      state_next = rState;
      oDmaBusy   = 1'b1;
      oMemAddr   = {rSrc, rIdx};
      oMemData   = rByte;
      oMemWe     = 1'b0;
      oCpuData   = reg_hit ? rSrc : 8'hFF;
      case (rState)
         IDLE: begin
            oDmaBusy = 1'b0;
            oMemAddr = iCpuAddr;
            oMemData = iCpuData;
            oMemWe   = iCpuWe && !reg_hit;
            oCpuData = reg_hit ? rSrc : iMemData;
            if (start_req) begin
               state_next = START;
            end
         end
         START: begin
            state_next = READ;
         end
         READ: begin
            state_next = WRITE;
         end
         WRITE: begin
            oMemAddr   = OAM_BASE + {8'h00, rIdx};
            oMemWe     = 1'b1;
            state_next = last_byte ? IDLE : READ;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a flat memory model on the bus and
// a reference model that treats a transfer as "OAM[i] becomes source[i]".
module tb_oam_dma_ctrl;

   localparam int LEN      = 160;
   localparam int BUSY_LEN = 2 * LEN + 1;

   logic        iClock   = 1'b0;
   logic        iReset   = 1'b1;
   logic [15:0] iCpuAddr = 16'hC000;
   logic [7:0]  iCpuData = 8'h00;
   logic        iCpuWe   = 1'b0;
   logic [7:0]  oCpuData;
   logic [15:0] oMemAddr;
   logic [7:0]  oMemData;
   logic        oMemWe;
   logic [7:0]  iMemData;
   logic        oDmaBusy;
   logic        oDmaDone;

   logic [7:0]  mem [0:65535];
   logic [7:0]  expOam [0:LEN-1];
   logic [7:0]  oamBefore [0:LEN-1];

   int checks     = 0;
   int errors     = 0;
   int cycleCount = 0;
   int busyTotal  = 0;
   int doneTotal  = 0;

   logic [15:0] wAddr [$];
   logic [7:0]  wData [$];
   int          wCycle [$];

   oam_dma_ctrl dut (
      .iClock  (iClock),
      .iReset  (iReset),
      .iCpuAddr(iCpuAddr),
      .iCpuData(iCpuData),
      .iCpuWe  (iCpuWe),
      .oCpuData(oCpuData),
      .oMemAddr(oMemAddr),
      .oMemData(oMemData),
      .oMemWe  (oMemWe),
      .iMemData(iMemData),
      .oDmaBusy(oDmaBusy),
      .oDmaDone(oDmaDone)
   );

   always #5 iClock = ~iClock;

   assign iMemData = mem[oMemAddr];

   // Memory model: combinational read, write committed at the clock edge.
   always @(posedge iClock) begin
      cycleCount++;
      if (oMemWe === 1'b1) mem[oMemAddr] = oMemData;
   end

   // Bus monitor sampled mid-cycle: logs every bus write and counts busy/done cycles.
   always @(negedge iClock) begin
      if (oMemWe === 1'b1) begin
         wAddr.push_back(oMemAddr);
         wData.push_back(oMemData);
         wCycle.push_back(cycleCount);
      end
      if (oDmaBusy === 1'b1) busyTotal++;
      if (oDmaDone === 1'b1) doneTotal++;
   end

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic idleBus();
      iCpuAddr = 16'hC000;
      iCpuData = 8'h00;
      iCpuWe   = 1'b0;
   endtask

   task automatic fillSource(input logic [7:0] src, input bit pattern);
      for (int i = 0; i < LEN; i++) begin
         mem[{src, 8'(i)}] = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
         expOam[i]         = mem[{src, 8'(i)}];
      end
   endtask

   task automatic fillOam();
      for (int i = 0; i < LEN; i++) begin
         mem[16'hFE00 + 16'(i)] = 8'($urandom);
         oamBefore[i]           = mem[16'hFE00 + 16'(i)];
      end
   endtask

   task automatic startDma(input logic [7:0] src, output int c);
      iCpuAddr = 16'hFF46;
      iCpuData = src;
      iCpuWe   = 1'b1;
      c        = cycleCount;
      tick();
      idleBus();
   endtask

   task automatic waitDone(output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < BUSY_LEN + 50; i++) begin
         @(negedge iClock);
         if (oDmaDone === 1'b1) begin
            timeout = 1'b0;
            break;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      int c;
      repeat (2) tick();
      checks++;
      if (oDmaBusy !== 1'b0 || oDmaDone !== 1'b0 || oMemAddr !== iCpuAddr) begin
         errors++;
         $display("[TB] FAIL reset_hold: busy=%b done=%b addr=%h expected 0 0 %h", oDmaBusy, oDmaDone, oMemAddr, iCpuAddr);
      end
      iReset = 1'b0;
      tick();
      startDma(8'hC7, c);
      repeat (5) tick();
      #3 iReset = 1'b1;
      #1;
      checks++;
      if (oDmaBusy !== 1'b0 || oDmaDone !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_async: busy=%b done=%b expected 0 0", oDmaBusy, oDmaDone);
      end
      iCpuAddr = 16'hFF46;
      #1;
      checks++;
      if (oCpuData !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_reg_read: got %h expected 00", oCpuData);
      end
      iCpuAddr = 16'hC000;
      #1;
      checks++;
      if (oCpuData !== mem[16'hC000]) begin
         errors++;
         $display("[TB] FAIL reset_mem_read: got %h expected %h", oCpuData, mem[16'hC000]);
      end
      tick();
      iReset = 1'b0;
      tick();
   endtask

   task automatic test_full_transfer();
      int c, b0, d0, l0;
      bit to;
      fillSource(8'hC1, 1'b1);
      fillOam();
      b0 = busyTotal;
      d0 = doneTotal;
      l0 = wAddr.size();
      iCpuAddr = 16'hFF46;
      iCpuData = 8'hC1;
      iCpuWe   = 1'b1;
      #1;
      checks++;
      if (oMemWe !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reg_write_forwarded: we=%b expected 0", oMemWe);
      end
      c = cycleCount;
      tick();
      idleBus();
      checks++;
      if (oDmaBusy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_rise: got %b expected 1", oDmaBusy);
      end
      waitDone(to);
      checks++;
      if (to) begin
         errors++;
         $display("[TB] FAIL full_timeout: no done pulse within bound");
      end
      checks++;
      if (busyTotal - b0 !== BUSY_LEN) begin
         errors++;
         $display("[TB] FAIL full_busy_len: got %0d expected %0d", busyTotal - b0, BUSY_LEN);
      end
      checks++;
      if (wAddr.size() - l0 !== LEN) begin
         errors++;
         $display("[TB] FAIL full_write_count: got %0d expected %0d", wAddr.size() - l0, LEN);
      end
      for (int k = 0; k < LEN && l0 + k < wAddr.size(); k++) begin
         checks++;
         if (wAddr[l0+k] !== 16'hFE00 + 16'(k) || wData[l0+k] !== expOam[k] || wCycle[l0+k] !== c + 3 + 2*k) begin
            errors++;
            $display("[TB] FAIL full_write[%0d]: addr=%h data=%h cyc=%0d expected %h %h %0d", k, wAddr[l0+k], wData[l0+k], wCycle[l0+k] - c, 16'hFE00 + 16'(k), expOam[k], 3 + 2*k);
         end
      end
      tick();
      checks++;
      if (oDmaDone !== 1'b0 || doneTotal - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL full_done_pulse: done=%b pulses=%0d expected 0 1", oDmaDone, doneTotal - d0);
      end
      for (int i = 0; i < LEN; i++) begin
         checks++;
         if (mem[16'hFE00 + 16'(i)] !== expOam[i]) begin
            errors++;
            $display("[TB] FAIL full_oam[%0d]: got %h expected %h", i, mem[16'hFE00 + 16'(i)], expOam[i]);
         end
      end
   endtask

   task automatic test_cpu_blocking();
      int c, b0, l0, hits;
      bit to;
      fillSource(8'hC1, 1'b0);
      mem[16'hD000] = 8'h11;
      b0 = busyTotal;
      l0 = wAddr.size();
      startDma(8'hC1, c);
      repeat (20) tick();
      iCpuAddr = 16'hC000;
      #1;
      checks++;
      if (oCpuData !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL busy_read: got %h expected ff", oCpuData);
      end
      iCpuAddr = 16'hD000;
      iCpuData = 8'h77;
      iCpuWe   = 1'b1;
      tick();
      idleBus();
      iCpuAddr = 16'hFF46;
      #1;
      checks++;
      if (oCpuData !== 8'hC1) begin
         errors++;
         $display("[TB] FAIL busy_reg_read: got %h expected c1", oCpuData);
      end
      idleBus();
      waitDone(to);
      hits = 0;
      for (int k = l0; k < wAddr.size(); k++) if (wAddr[k] === 16'hD000) hits++;
      checks++;
      if (to || hits != 0 || mem[16'hD000] !== 8'h11) begin
         errors++;
         $display("[TB] FAIL busy_write_blocked: timeout=%b d000_writes=%0d mem=%h expected 0 0 11", to, hits, mem[16'hD000]);
      end
      checks++;
      if (busyTotal - b0 !== BUSY_LEN) begin
         errors++;
         $display("[TB] FAIL blocking_busy_len: got %0d expected %0d", busyTotal - b0, BUSY_LEN);
      end
      tick();
   endtask

   task automatic test_write_during_busy();
      int c, b0, bad;
      bit to;
      fillSource(8'hD0, 1'b0);
      fillSource(8'hC1, 1'b0);
      b0 = busyTotal;
      startDma(8'hC1, c);
      repeat (40) tick();
      iCpuAddr = 16'hFF46;
      iCpuData = 8'hD0;
      iCpuWe   = 1'b1;
      tick();
      iCpuWe = 1'b0;
      #1;
      checks++;
      if (oCpuData !== 8'hC1) begin
         errors++;
         $display("[TB] FAIL restart_src: got %h expected c1", oCpuData);
      end
      idleBus();
      waitDone(to);
      checks++;
      if (to || busyTotal - b0 !== BUSY_LEN) begin
         errors++;
         $display("[TB] FAIL restart_busy_len: timeout=%b got %0d expected %0d", to, busyTotal - b0, BUSY_LEN);
      end
      bad = 0;
      for (int i = 0; i < LEN; i++) if (mem[16'hFE00 + 16'(i)] !== expOam[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL restart_oam: %0d bytes differ from source c1, expected 0", bad);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int c, d0, l0, bad;
      bit to;
      fillOam();
      fillSource(8'hC4, 1'b0);
      d0 = doneTotal;
      l0 = wAddr.size();
      startDma(8'hC4, c);
      while (cycleCount < c + 2 + 2*50) tick();
      #3 iReset = 1'b1;
      #1;
      checks++;
      if (oDmaBusy !== 1'b0 || oMemWe !== 1'b0 || oMemAddr !== iCpuAddr) begin
         errors++;
         $display("[TB] FAIL abort_outputs: busy=%b we=%b addr=%h expected 0 0 %h", oDmaBusy, oMemWe, oMemAddr, iCpuAddr);
      end
      tick();
      iReset = 1'b0;
      repeat (3) tick();
      checks++;
      if (doneTotal - d0 !== 0 || wAddr.size() - l0 !== 50) begin
         errors++;
         $display("[TB] FAIL abort_progress: done_pulses=%0d writes=%0d expected 0 50", doneTotal - d0, wAddr.size() - l0);
      end
      bad = 0;
      for (int i = 0; i < LEN; i++) begin
         if (mem[16'hFE00 + 16'(i)] !== ((i < 50) ? expOam[i] : oamBefore[i])) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL abort_oam: %0d bytes wrong, expected 0", bad);
      end
      fillSource(8'hC2, 1'b0);
      d0 = doneTotal;
      startDma(8'hC2, c);
      waitDone(to);
      bad = 0;
      for (int i = 0; i < LEN; i++) if (mem[16'hFE00 + 16'(i)] !== expOam[i]) bad++;
      checks++;
      if (to || bad != 0 || doneTotal - d0 !== 1) begin
         errors++;
         $display("[TB] FAIL after_abort_copy: timeout=%b bad=%0d pulses=%0d expected 0 0 1", to, bad, doneTotal - d0);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int c, c2, l0, bad;
      bit to;
      fillSource(8'hC5, 1'b0);
      startDma(8'hC5, c);
      waitDone(to);
      checks++;
      if (to) begin
         errors++;
         $display("[TB] FAIL b2b_first_timeout: no done pulse within bound");
      end
      fillSource(8'hC3, 1'b0);
      l0 = wAddr.size();
      startDma(8'hC3, c2);
      checks++;
      if (oDmaBusy !== 1'b1 || oDmaDone !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_restart: busy=%b done=%b expected 1 0", oDmaBusy, oDmaDone);
      end
      waitDone(to);
      bad = 0;
      for (int k = 0; k < LEN && l0 + k < wAddr.size(); k++) begin
         if (wAddr[l0+k] !== 16'hFE00 + 16'(k) || wData[l0+k] !== mem[16'hC300 + 16'(k)] || wCycle[l0+k] !== c2 + 3 + 2*k) bad++;
      end
      checks++;
      if (to || wAddr.size() - l0 !== LEN || bad != 0) begin
         errors++;
         $display("[TB] FAIL b2b_second_copy: timeout=%b writes=%0d bad=%0d expected 0 %0d 0", to, wAddr.size() - l0, bad, LEN);
      end
      tick();
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      test_reset();
      test_full_transfer();
      test_cpu_blocking();
      test_write_during_busy();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
